// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron array in signed 2.(W-2) fixed point.
// One shared squarer; each neuron is fetched then written back once per step.
module izh_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int W = 18,
    parameter int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    parameter logic signed [W-1:0] THRESH = 18'sh0_4CCC,
    parameter logic signed [W-1:0] V_INIT = 18'sh3_4CCD,
    parameter logic signed [W-1:0] U_INIT = 18'sh3_CCCD,
    // 18-bit image of the 4_6666 pattern (the top hex digit does not fit in W)
    parameter logic signed [W-1:0] C_INIT = 18'sh0_6666,
    parameter logic signed [W-1:0] D_INIT = 18'sh0_4CCD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 step_start,
    output logic                 busy,
    output logic                 step_done,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_sel,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [W-1:0]         cfg_wdata,
    output logic                 cfg_err,
    output logic [N_NEURONS-1:0] spike,
    input  logic [IDX_W-1:0]     mon_idx,
    output logic [W-1:0]         mon_v
);
    localparam int SW = W + 3;
    localparam logic signed [W-1:0] C14 = 18'sh1_6666;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE} state_t;

    state_t state_r, state_s;
    logic [IDX_W-1:0] idx_r;
    logic busy_r, step_done_r, cfg_err_r;
    logic [N_NEURONS-1:0] spike_r, fire_r, fire_next_s;
    logic start_s, last_s, cfg_ok_s, fire_s;

    logic signed [W-1:0] v_mem [N_NEURONS];
    logic signed [W-1:0] u_mem [N_NEURONS];
    logic signed [W-1:0] c_mem [N_NEURONS];
    logic signed [W-1:0] d_mem [N_NEURONS];
    logic signed [W-1:0] i_mem [N_NEURONS];
    logic [7:0]          ab_mem [N_NEURONS];

    logic signed [W-1:0] op_v_r, op_u_r, op_c_r, op_d_r, op_i_r;
    logic [3:0]          op_a_r, op_b_r;

    logic signed [2*W-1:0] prod_s;
    logic signed [W-1:0]   sq_s, new_v_s, new_u_s;
    logic signed [SW-1:0]  v_x_s, u_x_s, i_x_s, sum_s, du_s;

    function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] x);
        logic signed [W-1:0] r;
        if (x[SW-1:W-1] == {4{x[SW-1]}}) begin
            r = x[W-1:0];
        end else if (x[SW-1]) begin
            r = {1'b1, {(W-1){1'b0}}};
        end else begin
            r = {1'b0, {(W-1){1'b1}}};
        end
        return r;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and control decode
    always_comb begin
        state_s   = state_r;
        start_s   = (state_r == S_IDLE) && step_start && ena;
        last_s    = (int'(idx_r) == N_NEURONS - 1);
        cfg_ok_s  = cfg_we && (state_r == S_IDLE) && (int'(cfg_idx) < N_NEURONS);
        case (state_r)
            S_IDLE: begin
                if (start_s) state_s = S_FETCH;
                else         state_s = S_IDLE;
            end
            S_FETCH:  state_s = S_UPDATE;
            S_UPDATE: begin
                if (last_s) state_s = S_IDLE;
                else        state_s = S_FETCH;
            end
            default:  state_s = S_IDLE;
        endcase
    end

    // Euler update datapath; sums carry 3 guard bits before clamping
    always_comb begin
        prod_s = op_v_r * op_v_r;
        sq_s   = {prod_s[2*W-1], prod_s[2*W-4:W-2]};
        v_x_s  = SW'(op_v_r);
        u_x_s  = SW'(op_u_r);
        i_x_s  = SW'(op_i_r);
        sum_s  = SW'(sq_s) + v_x_s + (v_x_s >>> 2'd2) + SW'(C14 >>> 2'd2)
               - (u_x_s >>> 2'd2) + (i_x_s >>> 2'd2);
        du_s   = (((v_x_s >>> op_b_r) - u_x_s) >>> op_a_r) >>> 3'd4;
        fire_s = (op_v_r > THRESH);
        if (fire_s) begin
            new_v_s = op_c_r;
            new_u_s = sat(u_x_s + SW'(op_d_r));
        end else begin
            new_v_s = sat(v_x_s + (sum_s >>> 2'd2));
            new_u_s = sat(u_x_s + du_s);
        end
        fire_next_s = fire_r | (N_NEURONS'(fire_s) << idx_r);
    end

    // Neuron storage, config port, operand fetch and write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                v_mem[n]  <= V_INIT;
                u_mem[n]  <= U_INIT;
                c_mem[n]  <= C_INIT;
                d_mem[n]  <= D_INIT;
                i_mem[n]  <= '0;
                ab_mem[n] <= 8'h00;
            end
            op_v_r <= '0; op_u_r <= '0; op_c_r <= '0; op_d_r <= '0; op_i_r <= '0;
            op_a_r <= 4'h0; op_b_r <= 4'h0;
            idx_r       <= '0;
            busy_r      <= 1'b0;
            step_done_r <= 1'b0;
            cfg_err_r   <= 1'b0;
            spike_r     <= '0;
            fire_r      <= '0;
        end else begin
            step_done_r <= 1'b0;
            cfg_err_r   <= cfg_we && !cfg_ok_s;
            if (cfg_ok_s) begin
                case (cfg_sel)
                    3'd0:    i_mem[cfg_idx]  <= cfg_wdata;
                    3'd1:    ab_mem[cfg_idx] <= cfg_wdata[7:0];
                    3'd2:    c_mem[cfg_idx]  <= cfg_wdata;
                    3'd3:    d_mem[cfg_idx]  <= cfg_wdata;
                    3'd4:    v_mem[cfg_idx]  <= cfg_wdata;
                    3'd5:    u_mem[cfg_idx]  <= cfg_wdata;
                    default: begin end
                endcase
            end
            if (start_s) begin
                idx_r  <= '0;
                busy_r <= 1'b1;
                fire_r <= '0;
            end else if (state_r == S_FETCH) begin
                op_v_r <= v_mem[idx_r];
                op_u_r <= u_mem[idx_r];
                op_c_r <= c_mem[idx_r];
                op_d_r <= d_mem[idx_r];
                op_i_r <= i_mem[idx_r];
                op_a_r <= ab_mem[idx_r][3:0];
                op_b_r <= ab_mem[idx_r][7:4];
            end else if (state_r == S_UPDATE) begin
                v_mem[idx_r] <= new_v_s;
                u_mem[idx_r] <= new_u_s;
                fire_r       <= fire_next_s;
                if (last_s) begin
                    busy_r      <= 1'b0;
                    step_done_r <= 1'b1;
                    spike_r     <= fire_next_s;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end
        end
    end

    // Monitor read of v, zero for indices beyond the array
    always_comb begin
        mon_v = '0;
        if (int'(mon_idx) < N_NEURONS) begin
            mon_v = v_mem[mon_idx];
        end else begin
            mon_v = '0;
        end
    end

    assign busy      = busy_r;
    assign step_done = step_done_r;
    assign cfg_err   = cfg_err_r;
    assign spike     = spike_r;
endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed bench for izh_neuron_array: hand-computed vectors plus a small
// fixed-point reference model for the long driven run.
module tb_izh_neuron_array;
    localparam int N = 4;
    localparam int W = 18;
    localparam longint V_RST = -45875;   // 18'sh3_4CCD
    localparam longint U_RST = -13107;   // 18'sh3_CCCD
    localparam longint C_RST = 26214;    // 18'sh0_6666
    localparam longint D_RST = 19661;    // 18'sh0_4CCD
    localparam longint THR   = 19660;    // 18'sh0_4CCC
    localparam longint C14   = 91750;    // 18'sh1_6666

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena, step_start, busy, step_done, cfg_we, cfg_err;
    logic [2:0] cfg_sel;
    logic [1:0] cfg_idx, mon_idx;
    logic [W-1:0] cfg_wdata;
    logic [N-1:0] spike;
    logic signed [W-1:0] mon_v;

    izh_neuron_array #(.N_NEURONS(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .step_start(step_start),
        .busy(busy), .step_done(step_done), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .spike(spike), .mon_idx(mon_idx), .mon_v(mon_v)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic get_v(input int idx, output longint v);
        mon_idx = 2'(idx);
        #1;
        v = longint'(mon_v);
    endtask

    task automatic write_cfg(input logic [2:0] sel, input int idx, input logic [W-1:0] data);
        cfg_sel = sel; cfg_idx = 2'(idx); cfg_wdata = data; cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check("cfg_err_ok", cfg_err, 0);
    endtask

    task automatic do_step(output int lat, output int bcnt, output logic [N-1:0] sp);
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!step_done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        sp = spike;
    endtask

    task automatic do_reset();
        #2; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    longint mv[N], mu[N], mc[N], md[N], mi[N];
    int ma[N], mb[N];

    function automatic longint sat18(input longint x);
        if (x > 131071) return 131071;
        else if (x < -131072) return -131072;
        else return x;
    endfunction

    function automatic longint sq18(input longint v);
        logic [35:0] p;
        logic [17:0] s;
        p = 36'(v * v);
        s = {p[35], p[32:16]};
        return longint'($signed(s));
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = V_RST; mu[n] = U_RST; mc[n] = C_RST; md[n] = D_RST;
            mi[n] = 0; ma[n] = 0; mb[n] = 0;
        end
    endtask

    task automatic model_step(output logic [N-1:0] sp);
        longint v, u, sum;
        sp = '0;
        for (int n = 0; n < N; n++) begin
            v = mv[n]; u = mu[n];
            if (v > THR) begin
                mv[n] = mc[n];
                mu[n] = sat18(u + md[n]);
                sp[n] = 1'b1;
            end else begin
                sum = sq18(v) + v + (v >>> 2) + (C14 >>> 2) - (u >>> 2) + (mi[n] >>> 2);
                mv[n] = sat18(v + (sum >>> 2));
                mu[n] = sat18(u + ((((v >>> mb[n]) - u) >>> ma[n]) >>> 4));
            end
        end
    endtask

    initial begin
        int lat, bcnt, dcnt, ecnt, s0cnt;
        logic [N-1:0] sp, esp;
        logic [W-1:0] i_drive;
        longint v;

        rst_n = 1'b0; ena = 1'b1; step_start = 1'b0; cfg_we = 1'b0;
        cfg_sel = 3'd0; cfg_idx = 2'd0; cfg_wdata = '0; mon_idx = 2'd0;
        #12;
        for (int n = 0; n < N; n++) begin
            get_v(n, v);
            check("rst_v", v, V_RST);
        end
        check("rst_spike", spike, 0);
        check("rst_busy", busy, 0);
        check("rst_done", step_done, 0);
        check("rst_err", cfg_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // plain step from reset: -0.7 -> -45630 (about -0.69625)
        do_step(lat, bcnt, sp);
        check("lat", lat, 8);
        check("busy_cycles", bcnt, 8);
        check("step_spike", sp, 0);
        check("done_pulse", step_done, 1);
        @(posedge clk); #1;
        check("done_drop", step_done, 0);
        for (int n = 0; n < N; n++) begin
            get_v(n, v);
            check("step_v", v, -45630);
        end

        // asynchronous reset in the middle of a step
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        repeat (3) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check("mid_rst_busy", busy, 0);
        for (int n = 0; n < N; n++) begin
            get_v(n, v);
            check("mid_rst_v", v, V_RST);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (step_done) dcnt++;
        end
        check("mid_rst_no_done", dcnt, 0);

        // forced spike on neuron 2, then restored v shows u' = D_INIT
        write_cfg(3'd4, 2, 18'h0_8000);
        write_cfg(3'd5, 2, 18'h0_0000);
        do_step(lat, bcnt, sp);
        check("force_spike", sp, 4'b0100);
        get_v(2, v); check("force_v2", v, C_RST);
        get_v(0, v); check("force_v0", v, -45630);
        write_cfg(3'd4, 2, 18'h3_4CCD);
        do_step(lat, bcnt, sp);
        check("after_spike", sp, 4'b0000);
        get_v(2, v); check("v2_from_d", v, -47678);

        // u saturates at the max instead of wrapping
        do_reset();
        write_cfg(3'd5, 1, 18'h1_FFFF);
        write_cfg(3'd4, 1, 18'h0_8000);
        do_step(lat, bcnt, sp);
        check("sat_spike", sp, 4'b0010);
        get_v(1, v); check("sat_v1", v, C_RST);
        write_cfg(3'd4, 1, 18'h0_0000);
        do_step(lat, bcnt, sp);
        check("sat_spike2", sp, 4'b0000);
        get_v(1, v); check("sat_u_probe", v, -2458);

        // handshake: same-cycle write applies, writes/starts during busy rejected
        do_reset();
        cfg_sel = 3'd4; cfg_idx = 2'd0; cfg_wdata = 18'h0_8000;
        cfg_we = 1'b1; step_start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; step_start = 1'b0;
        dcnt = 0;
        ecnt = cfg_err ? 1 : 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin
                step_start = 1'b1; cfg_we = 1'b1;
                cfg_sel = 3'd4; cfg_idx = 2'd3; cfg_wdata = 18'h0_0000;
            end
            @(posedge clk); #1;
            step_start = 1'b0; cfg_we = 1'b0;
            if (step_done) dcnt++;
            if (cfg_err) ecnt++;
        end
        check("hs_done_count", dcnt, 1);
        check("hs_err_count", ecnt, 1);
        check("hs_spike", spike, 4'b0001);
        get_v(0, v); check("hs_v0", v, C_RST);
        get_v(3, v); check("hs_v3", v, -45630);

        // ena low ignores step_start; ena dropping mid-step does not stop it
        ena = 1'b0;
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        check("ena_busy", busy, 0);
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (step_done) dcnt++;
        end
        check("ena_no_done", dcnt, 0);
        ena = 1'b1;
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0; ena = 1'b0;
        lat = 0;
        while (!step_done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ena_drop_lat", lat, 8);
        ena = 1'b1;

        // long driven run against the reference model
        do_reset();
        model_reset();
        i_drive = 18'(8'hFF) << 10;
        write_cfg(3'd0, 0, i_drive);  mi[0] = longint'($signed(i_drive));
        write_cfg(3'd1, 3, 18'h0_0012); ma[3] = 2; mb[3] = 1;
        write_cfg(3'd2, 2, 18'h3_8000); mc[2] = -32768;
        write_cfg(3'd3, 2, 18'h0_4000); md[2] = 16384;
        s0cnt = 0;
        for (int s = 0; s < 200; s++) begin
            do_step(lat, bcnt, sp);
            model_step(esp);
            check("drive_lat", lat, 8);
            check("drive_spike", sp, esp);
            if (sp[0]) s0cnt++;
        end
        check("drive_n0_spikes_ge3", (s0cnt >= 3) ? 1 : 0, 1);
        for (int n = 0; n < N; n++) begin
            get_v(n, v);
            check("drive_v", v, mv[n]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
